load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory (7-bit word address, 32-bit data, MemRead/MemWrite, write on posedge Clk, combinational read).
- Accepts byte-addressed load/store requests from the execute stage.
- Performs byte, halfword and word accesses: sign/zero extension on loads, read-modify-write for sub-word stores.
- Flags misaligned accesses without touching memory.

Parameters:
- ADDR_W, 7: word-address width driven to data memory; request byte address is ADDR_W+2 bits.

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept a request
- ReqWrite  in  1  1 = store, 0 = load
- ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- ReqSigned  in  1  loads only: 1 = sign-extend
- ReqAddr  in  ADDR_W+2  byte address
- ReqWData  in  32  store data, right-justified
- RespValid  out  1  one-cycle completion pulse
- RespData  out  32  load result, 0 for stores and errors
- AlignErr  out  1  valid with RespValid: access was misaligned/illegal
- MemAddress  out  ADDR_W  word address = ReqAddr[ADDR_W+1:2]
- MemWriteData  out  32  word written to memory
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- MemReadData  in  32  memory read data, valid same cycle as MemRead

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state IDLE; ReqReady 1; RespValid 0; RespData 0; AlignErr 0; MemRead 0; MemWrite 0; MemAddress 0; MemWriteData 0; internal address, data and captured-word registers 0.
- MemRead and MemWrite decode from state, so asserting Rst mid-WR drops MemWrite immediately; no write occurs at the next edge.
- Little-endian lanes: offset 0 = bits [7:0], offset 3 = [31:24]; halfword offset 0 = [15:0], offset 2 = [31:16].
- Alignment: halfword requires ReqAddr[0]=0; word requires ReqAddr[1:0]=00; size 11 is always an error.
- Handshake: a request is accepted on the rising edge where ReqValid && ReqReady. ReqReady=1 only in IDLE. All request fields are latched at acceptance.
- State IDLE:
  - misaligned -> ERR
  - load -> RD
  - word store -> WR
  - sub-word store -> RD
- State RD: MemRead=1, MemAddress driven. MemReadData is captured at the closing edge. Next state: RESP for a load, WR for a store.
- State WR: MemWrite=1. MemWriteData is one of:
  - word store: ReqWData
  - sub-word store: captured word with the addressed lane(s) replaced by ReqWData[7:0] or [15:0]
  - Next state: RESP.
- State ERR: no memory enables. Next state: RESP with AlignErr=1 and RespData=0.
- State RESP: RespValid=1 for exactly one cycle.
  - Load: RespData = selected lane, sign- or zero-extended to 32.
  - Store: RespData = 0.
  - Next state: IDLE.
- Latency from the accept edge to the RespValid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 2 cycles
- A new request is accepted at the end of the RESP+1 (IDLE) cycle at the earliest; back-to-back throughput is one request per latency+1 cycles.
- MemRead and MemWrite are never both 1.
- Outside RD and WR, MemAddress holds its last value; MemWriteData holds its last value.
- ReqSigned is ignored for word loads and for stores.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state encoding IDLE/RD/WR/ERR/RESP
  - lane constants
- One combinational sub-module, lsu_lane_align:
  - extract/extend path: word, offset, size, signed -> load data
  - merge path: word, offset, size, data -> merged word
- The FSM and registers stay in load_store_unit.

Test Plan:
- Word store ReqAddr=0x10C, ReqWData=0xD83F003F -> one WR cycle with MemAddress=0x43, MemWrite=1, MemWriteData=0xD83F003F; RespValid 2 cycles after accept, AlignErr=0.
- Byte load 0x10F with memory word 0xD83F003F: signed -> RespData=0xFFFFFFD8; unsigned -> 0x000000D8; MemRead high exactly one cycle.
- Halfword store 0x1234 at 0x10E -> RD cycle, then WR with MemWriteData=0x1234003F; a following word load at 0x10C returns 0x1234003F.
- Byte store 0xAA at 0x10D -> WR with MemWriteData=0x1234AA3F; RespValid 3 cycles after accept.
- Misaligned halfword load at 0x10D, and word store at 0x10E -> AlignErr=1, RespData=0, MemRead=MemWrite=0 throughout, ReqReady back to 1 after RESP.
- Assert Rst mid-WR of a store of 0xFFFFFFFF to word 0x43 -> MemWrite falls immediately, all outputs at reset values; the memory word is unchanged; after release, ReqReady=1 and a word load returns the old value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

   localparam int WORD_W = 32;
   localparam int LANE_W = 8;
   localparam logic [WORD_W-1:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [WORD_W-1:0] HALF_MASK = 32'h0000_FFFF;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      ERR  = 3'd3,
      RESP = 3'd4
   } state_e;

   // Halfwords need an even byte offset, words a zero offset; size 11 never works.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction (loads) and lane merge (sub-word stores).
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] ld_word_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] ld_data_o,
   input  logic [31:0] st_word_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_word_o
);

   logic [4:0]  lane_sh;
   logic [31:0] ld_shifted;
   logic [31:0] lane_mask;

   assign lane_sh = {offset_i, 3'b000};

   // Shift the addressed lane down to bit 0 and sign/zero extend it.
   always_comb begin
      ld_shifted = ld_word_i >> lane_sh;
      ld_data_o  = ld_word_i;
      case (size_i)
         SZ_BYTE: ld_data_o = {{24{signed_i & ld_shifted[7]}},  ld_shifted[7:0]};
         SZ_HALF: ld_data_o = {{16{signed_i & ld_shifted[15]}}, ld_shifted[15:0]};
         default: ld_data_o = ld_word_i;
      endcase
   end

   // Replace only the addressed lane(s) of the old word with the store data.
   always_comb begin
      case (size_i)
         SZ_BYTE: lane_mask = BYTE_MASK << lane_sh;
         SZ_HALF: lane_mask = HALF_MASK << lane_sh;
         default: lane_mask = '1;
      endcase
      st_word_o = (st_word_i & ~lane_mask) | ((st_data_i << lane_sh) & lane_mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 7
)
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [1:0]        ReqSize,
   input  logic              ReqSigned,
   input  logic [ADDR_W+1:0] ReqAddr,
   input  logic [31:0]       ReqWData,
   output logic              RespValid,
   output logic [31:0]       RespData,
   output logic              AlignErr,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [31:0]       MemWriteData,
   output logic              MemRead,
   output logic              MemWrite,
   input  logic [31:0]       MemReadData
);

   state_e            state_q, state_d;
   logic              write_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [1:0]        off_q;
   logic              err_q;
   logic [31:0]       wdata_q;
   logic [31:0]       word_q;
   logic [ADDR_W-1:0] memaddr_q;
   logic [31:0]       memwdata_q;

   logic              accept;
   logic              bad_req;
   logic [31:0]       ld_data;
   logic [31:0]       st_merged;

   assign bad_req      = misaligned(ReqSize, ReqAddr[1:0]);
   assign accept       = ReqValid && ReqReady;
   assign MemAddress   = memaddr_q;
   assign MemWriteData = memwdata_q;

   lsu_lane_align u_align (
      .ld_word_i (word_q),
      .offset_i  (off_q),
      .size_i    (size_q),
      .signed_i  (signed_q),
      .ld_data_o (ld_data),
      .st_word_i (MemReadData),
      .st_data_i (wdata_q),
      .st_word_o (st_merged)
   );

   // State register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Request latch, memory address/data registers and captured read word.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         signed_q   <= 1'b0;
         off_q      <= 2'b00;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         word_q     <= '0;
         memaddr_q  <= '0;
         memwdata_q <= '0;
      end else begin
         if (accept) begin
            write_q  <= ReqWrite;
            size_q   <= ReqSize;
            signed_q <= ReqSigned;
            off_q    <= ReqAddr[1:0];
            err_q    <= bad_req;
            wdata_q  <= ReqWData;
            // Errored requests never reach memory, so the bus keeps its old address.
            if (!bad_req) memaddr_q <= ReqAddr[ADDR_W+1:2];
            if (!bad_req && ReqWrite && (ReqSize == SZ_WORD)) memwdata_q <= ReqWData;
         end
         if (state_q == RD) begin
            word_q <= MemReadData;
            if (write_q) memwdata_q <= st_merged;
         end
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_d   = state_q;
      ReqReady  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RespValid = 1'b0;
      AlignErr  = 1'b0;
      RespData  = '0;
      case (state_q)
         IDLE: begin
            ReqReady = 1'b1;
            if (ReqValid) begin
               if (bad_req)                     state_d = ERR;
               else if (!ReqWrite)              state_d = RD;
               else if (ReqSize == SZ_WORD)     state_d = WR;
               else                             state_d = RD;
            end
         end
         RD: begin
            MemRead = 1'b1;
            state_d = write_q ? WR : RESP;
         end
         WR: begin
            MemWrite = 1'b1;
            state_d  = RESP;
         end
         ERR: state_d = RESP;
         RESP: begin
            RespValid = 1'b1;
            AlignErr  = err_q;
            if (!write_q && !err_q) RespData = ld_data;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a byte-array reference.
module tb_load_store_unit;

   localparam int ADDR_W = 7;

   logic              Clk = 1'b0;
   logic              Rst;
   logic              ReqValid;
   logic              ReqReady;
   logic              ReqWrite;
   logic [1:0]        ReqSize;
   logic              ReqSigned;
   logic [ADDR_W+1:0] ReqAddr;
   logic [31:0]       ReqWData;
   logic              RespValid;
   logic [31:0]       RespData;
   logic              AlignErr;
   logic [ADDR_W-1:0] MemAddress;
   logic [31:0]       MemWriteData;
   logic              MemRead;
   logic              MemWrite;
   logic [31:0]       MemReadData;

   logic [31:0] mem   [0:127];
   logic [7:0]  ref_b [0:511];

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Rst(Rst),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .RespValid(RespValid), .RespData(RespData), .AlignErr(AlignErr),
      .MemAddress(MemAddress), .MemWriteData(MemWriteData),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
   );

   // Data memory: combinational read, write on rising edge.
   assign MemReadData = mem[MemAddress];
   always @(posedge Clk) if (MemWrite) mem[MemAddress] <= MemWriteData;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [6:0] idx);
      int b;
      b = int'(idx) * 4;
      return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
   endfunction

   task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [8:0] addr, input logic [31:0] wd);
      int          nb, base, exp_lat, exp_rd, exp_wr, got_lat, rd_n, wr_n;
      logic        err, both, addr_bad;
      logic [31:0] exp_resp, exp_mw, got_mw, got_resp, msk;
      logic        got_ae;
      // Reference: byte-level semantics straight from the access rules.
      err  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
      nb   = 1 << sz;
      base = int'(addr);
      exp_resp = 32'h0;
      exp_mw   = 32'h0;
      if (err) begin
         exp_lat = 2; exp_rd = 0; exp_wr = 0;
      end else if (!wr) begin
         exp_lat = 2; exp_rd = 1; exp_wr = 0;
         for (int k = 0; k < nb; k++) exp_resp |= 32'(ref_b[base+k]) << (8*k);
         if (nb < 4 && sg && exp_resp[8*nb-1]) begin
            msk = (32'd1 << (8*nb)) - 32'd1;
            exp_resp |= ~msk;
         end
      end else begin
         exp_lat = (nb == 4) ? 2 : 3;
         exp_rd  = (nb == 4) ? 0 : 1;
         exp_wr  = 1;
         for (int k = 0; k < nb; k++) ref_b[base+k] = wd[8*k +: 8];
         exp_mw = ref_word(addr[8:2]);
      end

      @(negedge Clk);
      check("ready_before", {31'b0, ReqReady}, 32'd1);
      ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
      ReqAddr = addr; ReqWData = wd;
      @(posedge Clk);
      @(negedge Clk);
      ReqValid = 1'b0;
      got_lat = 0; rd_n = 0; wr_n = 0; both = 1'b0; addr_bad = 1'b0;
      got_mw = 32'h0; got_resp = 32'h0; got_ae = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (MemRead) rd_n++;
         if (MemWrite) begin wr_n++; got_mw = MemWriteData; end
         if (MemRead && MemWrite) both = 1'b1;
         if ((MemRead || MemWrite) && MemAddress !== addr[8:2]) addr_bad = 1'b1;
         if (RespValid) begin
            got_lat = c; got_resp = RespData; got_ae = AlignErr;
            break;
         end
         @(negedge Clk);
      end
      if (got_lat == 0) begin
         check("resp_timeout", 32'd0, 32'd1);
      end else begin
         check("latency",    got_lat, exp_lat);
         check("resp_data",  got_resp, exp_resp);
         check("align_err",  {31'b0, got_ae}, {31'b0, err});
         check("rd_cycles",  rd_n, exp_rd);
         check("wr_cycles",  wr_n, exp_wr);
         check("rd_wr_both", {31'b0, both}, 32'd0);
         check("mem_addr",   {31'b0, addr_bad}, 32'd0);
         if (exp_wr != 0) check("mem_wdata", got_mw, exp_mw);
      end
      @(negedge Clk);
      check("ready_after", {31'b0, ReqReady}, 32'd1);
      check("resp_pulse",  {31'b0, RespValid}, 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] old_w;
      for (int i = 0; i < 128; i++) begin
         r = $urandom;
         mem[i] <= r;
         for (int k = 0; k < 4; k++) ref_b[4*i+k] = r[8*k +: 8];
      end
      Rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
      ReqSigned = 1'b0; ReqAddr = '0; ReqWData = '0;
      #3;
      check("rst_ready",  {31'b0, ReqReady},  32'd1);
      check("rst_rvalid", {31'b0, RespValid}, 32'd0);
      check("rst_rdata",  RespData, 32'd0);
      check("rst_aerr",   {31'b0, AlignErr},  32'd0);
      check("rst_mrd",    {31'b0, MemRead},   32'd0);
      check("rst_mwr",    {31'b0, MemWrite},  32'd0);
      check("rst_maddr",  {25'b0, MemAddress}, 32'd0);
      check("rst_mwdata", MemWriteData, 32'd0);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;

      // Directed sequence around word 0x43.
      run_req(1'b1, 2'b10, 1'b0, 9'h10C, 32'hD83F003F);
      run_req(1'b0, 2'b00, 1'b1, 9'h10F, 32'h0);
      run_req(1'b0, 2'b00, 1'b0, 9'h10F, 32'h0);
      run_req(1'b1, 2'b01, 1'b0, 9'h10E, 32'h0000_1234);
      run_req(1'b0, 2'b10, 1'b0, 9'h10C, 32'h0);
      run_req(1'b1, 2'b00, 1'b0, 9'h10D, 32'h0000_00AA);
      run_req(1'b0, 2'b10, 1'b1, 9'h10C, 32'h0);
      run_req(1'b0, 2'b01, 1'b1, 9'h10D, 32'h0);
      run_req(1'b1, 2'b10, 1'b0, 9'h10E, 32'hCAFEF00D);
      run_req(1'b0, 2'b11, 1'b0, 9'h000, 32'h0);
      run_req(1'b0, 2'b01, 1'b1, 9'h10E, 32'h0);

      // Reset asserted during the WR cycle of a word store.
      old_w = ref_word(7'h43);
      @(negedge Clk);
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
      ReqAddr = 9'h10C; ReqWData = 32'hFFFFFFFF;
      @(posedge Clk);
      @(negedge Clk);
      ReqValid = 1'b0;
      check("mid_wr_active", {31'b0, MemWrite}, 32'd1);
      #1 Rst = 1'b1;
      #1;
      check("rst_wr_drop",  {31'b0, MemWrite},  32'd0);
      check("rst_wr_mrd",   {31'b0, MemRead},   32'd0);
      check("rst_wr_ready", {31'b0, ReqReady},  32'd1);
      check("rst_wr_rv",    {31'b0, RespValid}, 32'd0);
      check("rst_wr_maddr", {25'b0, MemAddress}, 32'd0);
      check("rst_wr_mwd",   MemWriteData, 32'd0);
      @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      check("rst_wr_mem", mem[7'h43], old_w);
      run_req(1'b0, 2'b10, 1'b0, 9'h10C, 32'h0);

      // Randomized traffic.
      for (int n = 0; n < 200; n++) begin
         logic [31:0] ra, rc, rd;
         ra = $urandom; rc = $urandom; rd = $urandom;
         run_req(rc[0], rc[2:1], rc[3], ra[8:0], rd);
      end

      for (int i = 0; i < 128; i++) check("final_mem", mem[i], ref_word(7'(i)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
